// File: rtl/gon_bus_driver.sv
// GON bus driver: 2-entry packet FIFO broadcasting to NUM_MC multicast controllers,
// with an ID-configuration sequencer that keeps a shadow copy of every controller ID.
module gon_bus_driver #(
  parameter int unsigned NUM_MC    = 8,
  parameter int unsigned ID_SIZE   = 5,
  parameter int unsigned DATA_SIZE = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  // ID configuration
  input  logic                 cfg_start,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [ID_SIZE-1:0]   cfg_id,
  output logic                 cfg_done,
  output logic [NUM_MC-1:0]    set_id,
  output logic [ID_SIZE-1:0]   id_out,
  // Upstream packets
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [ID_SIZE-1:0]   in_tag,
  input  logic [DATA_SIZE-1:0] in_data,
  // Broadcast bus
  output logic                 bus_valid,
  output logic [ID_SIZE-1:0]   bus_tag,
  output logic [DATA_SIZE-1:0] bus_data,
  input  logic [NUM_MC-1:0]    bus_ready,
  // Drop reporting
  output logic                 drop_err,
  output logic [7:0]           drop_cnt
);

  localparam int unsigned IdxW = (NUM_MC > 1) ? $clog2(NUM_MC) : 1;

  typedef enum logic [1:0] {StIdle, StDrain, StLoad, StDone} state_e;

  state_e              state_q, state_d;
  logic [IdxW-1:0]     idx_q, idx_d;

  // FIFO storage and pointers
  logic [ID_SIZE-1:0]   tag_q  [2];
  logic [DATA_SIZE-1:0] data_q [2];
  logic                 rd_ptr_q, wr_ptr_q;
  logic [1:0]           count_q;

  // Shadow of the ID held by each controller
  logic [ID_SIZE-1:0]   shadow_q [NUM_MC];

  logic                 drop_err_q;
  logic [7:0]           drop_cnt_q;

  logic [NUM_MC-1:0]    match;
  logic                 empty, full;
  logic                 push, pop, deliver, drop;
  logic                 cfg_beat;

  assign empty = (count_q == 2'd0);
  assign full  = (count_q == 2'd2);

  // Head of the FIFO is always on the bus; valid only while packets may flow.
  assign bus_tag   = tag_q[rd_ptr_q];
  assign bus_data  = data_q[rd_ptr_q];
  assign bus_valid = !empty && ((state_q == StIdle) || (state_q == StDrain));

  // The FIFO cannot capture during reset, so never advertise readiness then.
  assign in_ready = !rst && !full && (state_q == StIdle) && !cfg_start;
  assign push     = in_valid && in_ready;

  // Match mask of controllers whose shadow ID equals the head tag
  always_comb begin
    match = '0;
    for (int unsigned i = 0; i < NUM_MC; i++) begin
      match[i] = (shadow_q[i] == bus_tag);
    end
  end

  // Deliver only when every matching controller is ready; drop when none match.
  assign deliver = bus_valid && (|match) && ((match & ~bus_ready) == '0);
  assign drop    = bus_valid && !(|match);
  assign pop     = deliver || drop;

  // Configuration handshake and strobes
  assign cfg_beat  = (state_q == StLoad) && cfg_valid;
  assign cfg_ready = (state_q == StLoad);
  assign cfg_done  = (state_q == StDone);
  assign id_out    = cfg_beat ? cfg_id : '0;

  // One-hot write strobe to the controller currently being loaded
  always_comb begin
    set_id = '0;
    for (int unsigned i = 0; i < NUM_MC; i++) begin
      set_id[i] = cfg_beat && (idx_q == IdxW'(i));
    end
  end

  assign drop_err = drop_err_q;
  assign drop_cnt = drop_cnt_q;

  // Next-state logic for the configuration sequencer
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      StIdle: begin
        if (cfg_start) state_d = StDrain;
      end
      StDrain: begin
        // Wait for in-flight packets so none is matched against a half-written table.
        if (empty) begin
          state_d = StLoad;
          idx_d   = '0;
        end
      end
      StLoad: begin
        if (cfg_valid) begin
          if (idx_q == IdxW'(NUM_MC - 1)) begin
            state_d = StDone;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
        idx_d   = '0;
      end
      default: begin
        state_d = StIdle;
        idx_d   = '0;
      end
    endcase
  end

  // Sequencer state and controller index registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // FIFO storage, pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < 2; i++) begin
        tag_q[i]  <= '0;
        data_q[i] <= '0;
      end
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) begin
        tag_q[wr_ptr_q]  <= in_tag;
        data_q[wr_ptr_q] <= in_data;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  // Shadow ID table; reset value matches the controllers' reset ID
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_MC; i++) begin
        shadow_q[i] <= '0;
      end
    end else if (cfg_beat) begin
      shadow_q[idx_q] <= cfg_id;
    end
  end

  // Sticky drop flag and saturating drop counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_err_q <= 1'b0;
      drop_cnt_q <= 8'd0;
    end else if (drop) begin
      drop_err_q <= 1'b1;
      if (drop_cnt_q != 8'hff) drop_cnt_q <= drop_cnt_q + 8'd1;
    end
  end

endmodule

// File: tb/tb_gon_bus_driver.sv
// Self-checking bench for gon_bus_driver: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_gon_bus_driver;

  localparam int NUM_MC    = 8;
  localparam int ID_SIZE   = 5;
  localparam int DATA_SIZE = 64;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 cfg_start, cfg_valid, cfg_ready, cfg_done;
  logic [ID_SIZE-1:0]   cfg_id, id_out;
  logic [NUM_MC-1:0]    set_id;
  logic                 in_valid, in_ready;
  logic [ID_SIZE-1:0]   in_tag, bus_tag;
  logic [DATA_SIZE-1:0] in_data, bus_data;
  logic                 bus_valid;
  logic [NUM_MC-1:0]    bus_ready;
  logic                 drop_err;
  logic [7:0]           drop_cnt;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [ID_SIZE-1:0]   tag;
    logic [DATA_SIZE-1:0] data;
  } pkt_t;

  always #5 clk = ~clk;

  gon_bus_driver #(
    .NUM_MC   (NUM_MC),
    .ID_SIZE  (ID_SIZE),
    .DATA_SIZE(DATA_SIZE)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cfg_start(cfg_start),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_id   (cfg_id),
    .cfg_done (cfg_done),
    .set_id   (set_id),
    .id_out   (id_out),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_tag   (in_tag),
    .in_data  (in_data),
    .bus_valid(bus_valid),
    .bus_tag  (bus_tag),
    .bus_data (bus_data),
    .bus_ready(bus_ready),
    .drop_err (drop_err),
    .drop_cnt (drop_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    cfg_start = 1'b0;
    cfg_valid = 1'b0;
    cfg_id    = '0;
    in_valid  = 1'b0;
    in_tag    = '0;
    in_data   = '0;
    bus_ready = '0;
  endtask

  task automatic apply_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Runs a full ID load with the FIFO assumed empty; bounded wait for LOAD.
  task automatic do_config(input logic [ID_SIZE-1:0] ids [NUM_MC]);
    int n = 0;
    cfg_start = 1'b1;
    cfg_valid = 1'b1;
    cfg_id    = ids[0];
    tick();
    cfg_start = 1'b0;
    while (!cfg_ready && n < 20) begin
      tick();
      n++;
    end
    tests++;
    if (n >= 20) begin
      fails++;
      $display("FAIL cfg_load_wait got cfg_ready=%0b exp=1 within 20 cycles", cfg_ready);
    end
    for (int k = 0; k < NUM_MC; k++) begin
      cfg_id = ids[k];
      tick();
    end
    cfg_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    logic [94:0] ov;
    clear_inputs();
    cfg_id    = 5'h1f;
    in_valid  = 1'b1;
    in_tag    = 5'd3;
    bus_ready = 8'hff;
    rst       = 1'b1;
    #1;
    ov = {cfg_ready, cfg_done, set_id, id_out, in_ready, bus_valid, bus_tag, bus_data,
          drop_err, drop_cnt};
    tests++;
    if (ov !== '0) begin
      fails++;
      $display("FAIL reset_outputs got=%h exp=0", ov);
    end
    tick();
    tick();
    clear_inputs();
    rst = 1'b0;
    #1;
    tests++;
    if (in_ready !== 1'b1 || bus_valid !== 1'b0) begin
      fails++;
      $display("FAIL post_reset got in_ready=%0b bus_valid=%0b exp 1/0", in_ready, bus_valid);
    end
    tick();
  endtask

  task automatic test_config();
    cfg_start = 1'b1;
    cfg_valid = 1'b1;
    cfg_id    = '0;
    #1;
    tests++;
    if (in_ready !== 1'b0) begin
      fails++;
      $display("FAIL cfg_start_blocks_push got in_ready=%0b exp=0", in_ready);
    end
    tick();
    cfg_start = 1'b0;
    #1;
    tests++;
    if (set_id !== '0 || cfg_ready !== 1'b0) begin
      fails++;
      $display("FAIL cfg_drain_quiet got set_id=%h cfg_ready=%0b exp 0/0", set_id, cfg_ready);
    end
    tick();
    for (int k = 0; k < NUM_MC; k++) begin
      logic [NUM_MC-1:0] exp_set;
      exp_set = '0;
      exp_set[k] = 1'b1;
      cfg_id = ID_SIZE'(k);
      #1;
      tests++;
      if (set_id !== exp_set || id_out !== ID_SIZE'(k) || cfg_ready !== 1'b1) begin
        fails++;
        $display("FAIL cfg_beat%0d got set_id=%h id_out=%0d exp set_id=%h id_out=%0d",
                 k, set_id, id_out, exp_set, k);
      end
      tick();
    end
    cfg_valid = 1'b0;
    #1;
    tests++;
    if (cfg_done !== 1'b1 || set_id !== '0) begin
      fails++;
      $display("FAIL cfg_done_pulse got cfg_done=%0b set_id=%h exp 1/0", cfg_done, set_id);
    end
    tick();
    tests++;
    if (cfg_done !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL cfg_done_end got cfg_done=%0b in_ready=%0b exp 0/1", cfg_done, in_ready);
    end
  endtask

  task automatic test_unicast();
    in_valid  = 1'b1;
    in_tag    = 5'd3;
    in_data   = 64'hA5;
    bus_ready = 8'h08;
    #1;
    tests++;
    if (in_ready !== 1'b1 || bus_valid !== 1'b0) begin
      fails++;
      $display("FAIL uni_accept got in_ready=%0b bus_valid=%0b exp 1/0", in_ready, bus_valid);
    end
    tick();
    in_valid = 1'b0;
    #1;
    tests++;
    if (bus_valid !== 1'b1 || bus_tag !== 5'd3 || bus_data !== 64'hA5) begin
      fails++;
      $display("FAIL uni_bus got v=%0b tag=%0d data=%h exp 1/3/a5", bus_valid, bus_tag, bus_data);
    end
    tick();
    tests++;
    if (bus_valid !== 1'b0) begin
      fails++;
      $display("FAIL uni_popped got bus_valid=%0b exp=0", bus_valid);
    end
  endtask

  task automatic test_multicast();
    logic [ID_SIZE-1:0] ids [NUM_MC];
    logic [7:0] partial [3];
    ids = '{5'd2, 5'd2, 5'd5, 5'd0, 5'd1, 5'd3, 5'd4, 5'd6};
    partial = '{8'h01, 8'h02, 8'hFD};
    bus_ready = '0;
    do_config(ids);
    in_valid = 1'b1;
    in_tag   = 5'd2;
    in_data  = 64'h1234_5678_9abc_def0;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      bus_ready = partial[k];
      #1;
      tests++;
      if (bus_valid !== 1'b1 || bus_data !== 64'h1234_5678_9abc_def0) begin
        fails++;
        $display("FAIL mc_hold%0d got v=%0b data=%h exp held", k, bus_valid, bus_data);
      end
      tick();
    end
    bus_ready = 8'h03;
    #1;
    tests++;
    if (bus_valid !== 1'b1) begin
      fails++;
      $display("FAIL mc_release got bus_valid=%0b exp=1", bus_valid);
    end
    tick();
    tests++;
    if (bus_valid !== 1'b0) begin
      fails++;
      $display("FAIL mc_popped got bus_valid=%0b exp=0", bus_valid);
    end
  endtask

  task automatic test_drop();
    bus_ready = '0;
    in_valid  = 1'b1;
    in_tag    = 5'd7;
    in_data   = 64'h77;
    tick();
    in_valid = 1'b0;
    #1;
    tests++;
    if (bus_valid !== 1'b1 || drop_err !== 1'b0) begin
      fails++;
      $display("FAIL drop_head got v=%0b err=%0b exp 1/0", bus_valid, drop_err);
    end
    tick();
    tests++;
    if (bus_valid !== 1'b0 || drop_err !== 1'b1 || drop_cnt !== 8'd1) begin
      fails++;
      $display("FAIL drop_done got v=%0b err=%0b cnt=%0d exp 0/1/1", bus_valid, drop_err, drop_cnt);
    end
    in_valid  = 1'b1;
    in_tag    = 5'd5;
    in_data   = 64'h55;
    bus_ready = 8'h04;
    tick();
    in_valid = 1'b0;
    #1;
    tests++;
    if (bus_valid !== 1'b1 || bus_tag !== 5'd5) begin
      fails++;
      $display("FAIL drop_next got v=%0b tag=%0d exp 1/5", bus_valid, bus_tag);
    end
    tick();
    tests++;
    if (bus_valid !== 1'b0 || drop_cnt !== 8'd1 || drop_err !== 1'b1) begin
      fails++;
      $display("FAIL drop_next_pop got v=%0b cnt=%0d err=%0b exp 0/1/1", bus_valid, drop_cnt,
               drop_err);
    end
  endtask

  task automatic test_fifo_full();
    bus_ready = '0;
    in_valid  = 1'b1;
    in_tag    = 5'd5;
    in_data   = 64'hD1;
    tick();
    in_data = 64'hD2;
    #1;
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL full_one got in_ready=%0b exp=1", in_ready);
    end
    tick();
    in_data = 64'hD3;
    #1;
    tests++;
    if (in_ready !== 1'b0 || bus_data !== 64'hD1) begin
      fails++;
      $display("FAIL full_two got in_ready=%0b data=%h exp 0/d1", in_ready, bus_data);
    end
    tick();
    bus_ready = 8'h04;
    #1;
    tests++;
    if (in_ready !== 1'b0 || bus_data !== 64'hD1) begin
      fails++;
      $display("FAIL full_hold got in_ready=%0b data=%h exp 0/d1", in_ready, bus_data);
    end
    tick();
    tests++;
    if (in_ready !== 1'b1 || bus_valid !== 1'b1 || bus_data !== 64'hD2) begin
      fails++;
      $display("FAIL full_pop1 got rdy=%0b v=%0b data=%h exp 1/1/d2", in_ready, bus_valid, bus_data);
    end
    tick();
    in_valid = 1'b0;
    #1;
    tests++;
    if (bus_valid !== 1'b1 || bus_data !== 64'hD3) begin
      fails++;
      $display("FAIL full_pushpop got v=%0b data=%h exp 1/d3", bus_valid, bus_data);
    end
    tick();
    tests++;
    if (bus_valid !== 1'b0) begin
      fails++;
      $display("FAIL full_empty got bus_valid=%0b exp=0", bus_valid);
    end
  endtask

  task automatic test_drain_reconfig();
    logic [94:0] ov;
    bus_ready = '0;
    in_valid  = 1'b1;
    in_tag    = 5'd5;
    in_data   = 64'hE1;
    tick();
    in_data = 64'hE2;
    tick();
    in_valid  = 1'b0;
    cfg_start = 1'b1;
    cfg_valid = 1'b1;
    cfg_id    = 5'd9;
    #1;
    tests++;
    if (in_ready !== 1'b0) begin
      fails++;
      $display("FAIL drain_block got in_ready=%0b exp=0", in_ready);
    end
    tick();
    tests++;
    if (bus_valid !== 1'b1 || cfg_ready !== 1'b0 || set_id !== '0) begin
      fails++;
      $display("FAIL drain_state got v=%0b cfg_rdy=%0b set=%h exp 1/0/0", bus_valid, cfg_ready,
               set_id);
    end
    tick();
    bus_ready = 8'h04;
    #1;
    tests++;
    if (set_id !== '0 || bus_data !== 64'hE1) begin
      fails++;
      $display("FAIL drain_pop1 got set=%h data=%h exp 0/e1", set_id, bus_data);
    end
    tick();
    tests++;
    if (set_id !== '0 || in_ready !== 1'b0 || bus_data !== 64'hE2 || bus_valid !== 1'b1) begin
      fails++;
      $display("FAIL drain_pop2 got set=%h rdy=%0b data=%h v=%0b exp 0/0/e2/1", set_id, in_ready,
               bus_data, bus_valid);
    end
    tick();
    tests++;
    if (bus_valid !== 1'b0 || cfg_ready !== 1'b0) begin
      fails++;
      $display("FAIL drain_empty got v=%0b cfg_rdy=%0b exp 0/0", bus_valid, cfg_ready);
    end
    tick();
    tests++;
    if (cfg_ready !== 1'b1 || set_id !== 8'h01 || id_out !== 5'd9) begin
      fails++;
      $display("FAIL drain_load got cfg_rdy=%0b set=%h id=%0d exp 1/01/9", cfg_ready, set_id, id_out);
    end
    cfg_start = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;
    ov = {cfg_ready, cfg_done, set_id, id_out, in_ready, bus_valid, bus_tag, bus_data,
          drop_err, drop_cnt};
    tests++;
    if (ov !== '0) begin
      fails++;
      $display("FAIL midload_reset got=%h exp=0", ov);
    end
    tick();
    clear_inputs();
    rst = 1'b0;
    // Tag 0 must now match every controller, including the two just loaded with 9.
    in_valid  = 1'b1;
    in_tag    = 5'd0;
    in_data   = 64'hF0;
    bus_ready = 8'hFE;
    tick();
    in_valid = 1'b0;
    tick();
    tests++;
    if (bus_valid !== 1'b1 || bus_data !== 64'hF0) begin
      fails++;
      $display("FAIL shadow_zero_hold got v=%0b data=%h exp 1/f0", bus_valid, bus_data);
    end
    bus_ready = 8'hFF;
    tick();
    in_valid = 1'b1;
    in_tag   = 5'd9;
    tick();
    in_valid = 1'b0;
    tick();
    tests++;
    if (bus_valid !== 1'b0 || drop_cnt !== 8'd1 || drop_err !== 1'b1) begin
      fails++;
      $display("FAIL shadow_zero_drop got v=%0b cnt=%0d err=%0b exp 0/1/1", bus_valid, drop_cnt,
               drop_err);
    end
  endtask

  task automatic test_drop_saturate();
    apply_reset();
    in_valid  = 1'b1;
    in_tag    = 5'd1;
    in_data   = 64'h1;
    bus_ready = '0;
    for (int k = 0; k < 300; k++) tick();
    in_valid = 1'b0;
    tick();
    tick();
    tests++;
    if (drop_cnt !== 8'd255 || drop_err !== 1'b1) begin
      fails++;
      $display("FAIL drop_saturate got cnt=%0d err=%0b exp 255/1", drop_cnt, drop_err);
    end
  endtask

  task automatic test_random();
    logic [ID_SIZE-1:0] ids [NUM_MC];
    int   mid [NUM_MC];
    pkt_t q [$];
    int   mode;  // 0 idle, 1 drain, 2 load, 3 done
    int   idx;
    int   dcnt;
    bit   derr;
    bit   pending;
    apply_reset();
    for (int k = 0; k < NUM_MC; k++) ids[k] = ID_SIZE'($urandom_range(0, 9));
    do_config(ids);
    for (int k = 0; k < NUM_MC; k++) mid[k] = int'(ids[k]);
    mode = 0; idx = 0; dcnt = 0; derr = 0; pending = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      int sz;
      bit exp_bv, exp_ir, any, all, dlv, drp;
      logic [NUM_MC-1:0]  exp_set;
      logic [ID_SIZE-1:0] exp_id;
      if (!pending) begin
        in_valid = ($urandom % 3) != 0;
        in_tag   = ID_SIZE'($urandom_range(0, 9));
        in_data  = {$urandom, $urandom};
      end
      bus_ready = (($urandom % 4) == 0) ? 8'hFF : 8'($urandom);
      cfg_start = ($urandom % 50) == 0;
      cfg_valid = $urandom % 2;
      cfg_id    = ID_SIZE'($urandom_range(0, 9));
      #1;
      sz      = q.size();
      exp_bv  = (sz > 0) && (mode == 0 || mode == 1);
      exp_ir  = (sz < 2) && (mode == 0) && !cfg_start;
      exp_set = (mode == 2 && cfg_valid) ? NUM_MC'(1 << idx) : '0;
      exp_id  = (mode == 2 && cfg_valid) ? cfg_id : '0;
      tests++;
      if (bus_valid !== exp_bv) begin
        fails++;
        $display("FAIL rnd_bus_valid cyc=%0d got=%0b exp=%0b", cyc, bus_valid, exp_bv);
      end
      tests++;
      if (in_ready !== exp_ir) begin
        fails++;
        $display("FAIL rnd_in_ready cyc=%0d got=%0b exp=%0b", cyc, in_ready, exp_ir);
      end
      tests++;
      if (cfg_ready !== (mode == 2) || cfg_done !== (mode == 3)) begin
        fails++;
        $display("FAIL rnd_cfg_hs cyc=%0d got rdy=%0b done=%0b mode=%0d", cyc, cfg_ready,
                 cfg_done, mode);
      end
      tests++;
      if (set_id !== exp_set || id_out !== exp_id) begin
        fails++;
        $display("FAIL rnd_set_id cyc=%0d got %h/%0d exp %h/%0d", cyc, set_id, id_out, exp_set,
                 exp_id);
      end
      tests++;
      if (drop_err !== derr || drop_cnt !== 8'(dcnt)) begin
        fails++;
        $display("FAIL rnd_drop cyc=%0d got err=%0b cnt=%0d exp %0b/%0d", cyc, drop_err, drop_cnt,
                 derr, dcnt);
      end
      if (exp_bv) begin
        tests++;
        if (bus_tag !== q[0].tag || bus_data !== q[0].data) begin
          fails++;
          $display("FAIL rnd_head cyc=%0d got %0d/%h exp %0d/%h", cyc, bus_tag, bus_data,
                   q[0].tag, q[0].data);
        end
      end
      // Advance the reference model by one cycle
      dlv = 0;
      drp = 0;
      if (exp_bv) begin
        any = 0;
        all = 1;
        for (int i = 0; i < NUM_MC; i++) begin
          if (mid[i] == int'(q[0].tag)) begin
            any = 1;
            if (!bus_ready[i]) all = 0;
          end
        end
        if (!any) drp = 1;
        else if (all) dlv = 1;
      end
      if (drp) begin
        derr = 1;
        if (dcnt < 255) dcnt++;
      end
      if (drp || dlv) void'(q.pop_front());
      if (in_valid && exp_ir) q.push_back('{in_tag, in_data});
      pending = in_valid && !exp_ir;
      case (mode)
        0: if (cfg_start) mode = 1;
        1: if (sz == 0) begin mode = 2; idx = 0; end
        2: if (cfg_valid) begin
             mid[idx] = int'(cfg_id);
             if (idx == NUM_MC - 1) mode = 3;
             else idx++;
           end
        default: begin mode = 0; idx = 0; end
      endcase
      tick();
    end
    clear_inputs();
  endtask

  initial begin
    rst = 1'b0;
    clear_inputs();
    #2;
    test_reset();
    test_config();
    test_unicast();
    test_multicast();
    test_drop();
    test_fifo_full();
    test_drain_reconfig();
    test_drop_saturate();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/gon_bus_driver.md
Name: gon_bus_driver

Overview:
- Upstream stage of the GON multicast controllers.
- Accepts tagged packets from the global buffer side, holds them in a 2-entry FIFO, and broadcasts tag, data and valid to NUM_MC controllers.
- Commits a packet only when every controller whose ID matches the tag is ready.
- Also runs the ID-configuration sequence: pulses set_id to each controller in turn and keeps a shadow copy of the IDs, so it can compute the match set and drop packets that no controller accepts.

Parameters:
- NUM_MC, 8, number of downstream multicast controllers (>=2).
- ID_SIZE, 5, tag/ID width.
- DATA_SIZE, 64, payload width.

Ports:
- clk  input  1  clock.
- rst  input  1  reset; one clock; reset is asynchronous and active-high.
- cfg_start  input  1  request to (re)load all controller IDs.
- cfg_valid  input  1  config ID beat valid.
- cfg_ready  output  1  config ID beat accepted.
- cfg_id  input  ID_SIZE  ID for the current controller index.
- cfg_done  output  1  one-cycle pulse after the last ID is written.
- set_id  output  NUM_MC  one-hot write strobe to the controllers.
- id_out  output  ID_SIZE  ID value broadcast to the controllers' id_in.
- in_valid  input  1  upstream packet valid.
- in_ready  output  1  upstream packet accepted.
- in_tag  input  ID_SIZE  packet tag.
- in_data  input  DATA_SIZE  packet payload.
- bus_valid  output  1  broadcast valid, shared by all controllers.
- bus_tag  output  ID_SIZE  broadcast tag.
- bus_data  output  DATA_SIZE  broadcast payload.
- bus_ready  input  NUM_MC  per-controller ready_out (already gated by tag==id).
- drop_err  output  1  sticky; set when a packet matched no controller.
- drop_cnt  output  8  saturating count of dropped packets.

Behaviour:
- Reset values: all outputs 0; FIFO empty; shadow ID table all 0 (matches controller reset ID); FSM in IDLE; index 0.
- FIFO: 2 entries of {tag, data}; bus_* always show the head entry; bus_valid = !empty && state==IDLE.
- Push: in_valid && in_ready. in_ready = (count<2) && state==IDLE && !cfg_start.
- Push and pop in the same cycle are allowed at count 1; count stays 1.
- Match mask: bit i = (shadow_id[i] == bus_tag).
- Pop (deliver): bus_valid && |mask && ((mask & ~bus_ready) == 0). Data is consumed the same cycle; no added latency beyond the FIFO register, so input to bus is 1 cycle when empty.
- Pop (drop): bus_valid && mask==0. Head is discarded in 1 cycle, drop_err set, drop_cnt incremented (saturates at 255).
- Partial readiness (some matching controllers not ready): hold the head; bus_* stable; no timeout.
- FSM states IDLE, DRAIN, LOAD, DONE.
- IDLE: cfg_start seen -> DRAIN. cfg_start is level-sampled; it blocks new pushes the same cycle.
- DRAIN: stay until FIFO empty; pops continue (bus_valid stays 1 while draining, as an exception to the IDLE-only rule). Then -> LOAD with index=0.
- LOAD:
  - cfg_ready=1.
  - On a cfg_valid beat: set_id[index]=1 for that cycle, id_out=cfg_id, shadow_id[index]<=cfg_id, index++.
  - Beat at index NUM_MC-1 -> DONE.
  - set_id is combinational from the beat: 0 when no beat.
- DONE: cfg_done=1 for one cycle; index<=0; -> IDLE.
- cfg_start held high in IDLE after DONE restarts the sequence; it is a level request.
- cfg_valid outside LOAD is ignored (cfg_ready=0).
- In_valid is ignored outside IDLE; upstream must hold it stable until in_ready.
- Duplicate IDs are legal: the mask then has multiple bits, giving a true multicast that waits for all of them.
- Reset mid-LOAD: the sequence aborts, the shadow table returns to 0, and drop_err/drop_cnt clear. The controllers also reset, so state stays consistent.
- drop_err clears only on rst.

Test Plan:
- Config: cfg_start, then IDs 0..7 with cfg_valid constant -> set_id walks 0x01..0x80 on 8 consecutive cycles with id_out=0..7; cfg_done pulses on the 9th cycle.
- Unicast: after config, send tag=3, data=0xA5; bus_ready=0x08 -> bus_valid 1 cycle after accept, popped that cycle, FIFO empty next.
- Multicast backpressure: IDs {2,2,5,...}, tag=2; bus_ready=0x01, then 0x03 -> packet held while 0x01, popped on 0x03.
- Drop: tag=7, no ID 7 configured -> head dropped in 1 cycle, drop_err=1, drop_cnt=1; next packet proceeds.
- FIFO full: bus_ready=0, push 2 packets -> in_ready=0. Release -> back-to-back pops; simultaneous push/pop at count 1 keeps count 1.
- Drain then reconfigure: 2 packets queued, cfg_start -> in_ready=0, set_id stays 0 until both pop, then LOAD. Assert rst mid-LOAD -> all outputs 0, shadow IDs 0.
